// File: rtl/btb_predictor_if.sv
// btb_predictor_if: fetch lookup, branch-unit training and invalidate signals of the BTB
interface btb_predictor_if;
    logic        invalidate_all_i;
    logic [31:0] lookup_pc_i;
    logic        lookup_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic [31:0] update_target_i;
    logic        update_taken_i;
    logic        update_is_branch_i;
    logic        init_done_o;
    modport master (
        output invalidate_all_i, lookup_pc_i, update_valid_i, update_pc_i,
               update_target_i, update_taken_i, update_is_branch_i,
        input  lookup_hit_o, pred_taken_o, pred_target_o, init_done_o
    );
    modport slave (
        input  invalidate_all_i, lookup_pc_i, update_valid_i, update_pc_i,
               update_target_i, update_taken_i, update_is_branch_i,
        output lookup_hit_o, pred_taken_o, pred_target_o, init_done_o
    );
endinterface

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit counters and an init/invalidate sweep
module btb_predictor #(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = 30 - IDX_W
) (
    input logic          clk,
    input logic          rst,
    btb_predictor_if.slave bus
);
    typedef enum logic {INIT, RUN} state_e;
    state_e             state_q;
    logic [IDX_W-1:0]   sweep_q;
    logic               init_done_q;
    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [IDX_W-1:0]   l_idx, u_idx, wr_idx;
    logic [TAG_W-1:0]   l_tag, u_tag;
    logic               l_hit, u_hit, u_go, wr_en, wr_valid, wr_tag_en, wr_tgt_en;
    logic [1:0]         u_ctr, wr_ctr;

    // Same-cycle lookup; everything misses until the sweep has finished
    always_comb begin
        l_idx = bus.lookup_pc_i[IDX_W+1:2];
        l_tag = bus.lookup_pc_i[31:IDX_W+2];
        l_hit = state_q == RUN && valid_q[l_idx] && tag_q[l_idx] == l_tag;
        bus.lookup_hit_o  = l_hit;
        bus.pred_taken_o  = l_hit && ctr_q[l_idx][1];
        bus.pred_target_o = (l_hit && ctr_q[l_idx][1]) ? target_q[l_idx] : bus.lookup_pc_i + 32'd4;
        bus.init_done_o   = init_done_q;
    end

    // Single write port: sweep clear in INIT, training/allocation in RUN
    always_comb begin
        u_idx     = bus.update_pc_i[IDX_W+1:2];
        u_tag     = bus.update_pc_i[31:IDX_W+2];
        u_ctr     = ctr_q[u_idx];
        u_hit     = valid_q[u_idx] && tag_q[u_idx] == u_tag;
        u_go      = state_q == RUN && bus.update_valid_i && !bus.invalidate_all_i && !rst;
        wr_en     = state_q == INIT || (u_go && (u_hit || bus.update_taken_i));
        wr_idx    = state_q == INIT ? sweep_q : u_idx;
        wr_valid  = state_q == RUN;
        wr_tag_en = state_q == RUN;
        wr_tgt_en = state_q == RUN && (bus.update_taken_i || !bus.update_is_branch_i);
        wr_ctr    = state_q == INIT            ? 2'd0 :
                    !bus.update_is_branch_i    ? 2'd3 :
                    !u_hit                     ? 2'd2 :
                    bus.update_taken_i         ? (u_ctr == 2'd3 ? 2'd3 : u_ctr + 2'd1) :
                                                 (u_ctr == 2'd0 ? 2'd0 : u_ctr - 2'd1);
    end

    // Entry storage; valid and ctr are cleared by the sweep, tag/target need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            ctr_q[wr_idx]   <= wr_ctr;
            if (wr_tag_en) tag_q[wr_idx]    <= u_tag;
            if (wr_tgt_en) target_q[wr_idx] <= bus.update_target_i;
        end
    end

    // INIT/RUN sweep FSM with registered init_done
    always_ff @(posedge clk) begin
        if (rst || bus.invalidate_all_i) begin
            state_q     <= INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == INIT) begin
            sweep_q <= sweep_q + 1'b1;
            if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                state_q     <= RUN;
                init_done_q <= 1'b1;
            end
        end
    end
endmodule
